// File: rtl/adc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : adc_pkg
//  Description : Shared definitions for the XADC multi-channel capture block:
//                capture FSM state encoding, XADC DRP address constants and
//                DRP data width.
//  Revision    : 1.0 - initial release
// ============================================================================
package adc_pkg;

    // Width of the XADC DRP read-data bus
    localparam int DRP_DATA_W = 16;

    // XADC status-register addresses of interest
    localparam logic [6:0] XADC_ADDR_TEMP  = 7'h00;
    localparam logic [6:0] XADC_ADDR_VPVN  = 7'h03;
    localparam logic [6:0] XADC_ADDR_VAUX0 = 7'h10;

    // Capture FSM states
    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DRDY = 2'd2,
        ST_ACCUM     = 2'd3
    } adc_state_e;

endpackage : adc_pkg
`default_nettype wire

// File: rtl/adc_ch_accum.sv
`default_nettype none
// ============================================================================
//  Module      : adc_ch_accum
//  Description : NUM_CH-entry accumulator + sample-count bank with a single
//                read-modify-write port. On a write the addressed entry adds
//                the new sample; when its count wraps (2^AVG_LOG2 samples)
//                done_o is high and avg_o carries the truncated mean, and the
//                entry's accumulator restarts from zero.
//  Ports       : clk, rst_n   - clock, asynchronous active-low reset
//                wr_en_i      - perform the read-modify-write this cycle
//                idx_i        - entry index (0..NUM_CH-1)
//                sample_i     - new sample
//                done_o       - (comb) this write completes an average
//                avg_o        - (comb) averaged result for this write
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_ch_accum #(
    parameter int NUM_CH   = 4,
    parameter int OUT_W    = 12,
    parameter int AVG_LOG2 = 0,
    parameter int IDX_W    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en_i,
    input  logic [IDX_W-1:0] idx_i,
    input  logic [OUT_W-1:0] sample_i,
    output logic             done_o,
    output logic [OUT_W-1:0] avg_o
);

    // Sum of 2^AVG_LOG2 OUT_W-bit samples always fits in this width
    localparam int ACC_W = OUT_W + AVG_LOG2;

    logic [ACC_W-1:0] acc_q [NUM_CH];
    logic [ACC_W-1:0] sum_d;

    assign sum_d = acc_q[idx_i] + ACC_W'(sample_i);
    // Dropping the low AVG_LOG2 bits is the truncating divide
    assign avg_o = sum_d[ACC_W-1:AVG_LOG2];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                acc_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            acc_q[idx_i] <= done_o ? '0 : sum_d;
        end
    end

    generate
        if (AVG_LOG2 == 0) begin : g_passthru
            // Every sample is its own average
            assign done_o = 1'b1;
        end else begin : g_avg
            logic [AVG_LOG2-1:0] cnt_q [NUM_CH];

            // Count is about to wrap to zero on this write
            assign done_o = &cnt_q[idx_i];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < NUM_CH; i++) begin
                        cnt_q[i] <= '0;
                    end
                end else if (wr_en_i) begin
                    cnt_q[idx_i] <= cnt_q[idx_i] + 1'b1;
                end
            end
        end
    endgenerate

endmodule : adc_ch_accum
`default_nettype wire

// File: rtl/adc_multich_capture.sv
`default_nettype none
// ============================================================================
//  Module      : adc_multich_capture
//  Description : XADC multi-channel result capture. Watches eoc/channel from
//                the XADC, issues a DRP read for each completed conversion on
//                an enabled channel, optionally averages 2^AVG_LOG2 samples
//                per channel and offers {channel, result} on a valid/ready
//                stream. Fully synchronous to clk.
//  Ports       : clk, rst_n        - DRP clock, asynchronous active-low reset
//                enable            - accept new EOCs
//                eoc_in/channel_in - XADC end-of-conversion and channel
//                den_out/daddr_out - DRP read request
//                drdy_in/do_in     - DRP read response
//                m_valid/m_ready/m_data/m_ch - result stream
//                overrun/timeout_err - sticky error flags
//                clr_flags         - clear both sticky flags
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_multich_capture
    import adc_pkg::*;
#(
    parameter int         NUM_CH      = 4,
    parameter logic [4:0] CH_BASE     = XADC_ADDR_VAUX0[4:0],
    parameter int         OUT_W       = 12,
    parameter int         AVG_LOG2    = 0,
    parameter int         TIMEOUT_CYC = 64,
    localparam int        CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  eoc_in,
    input  logic [4:0]            channel_in,
    output logic                  den_out,
    output logic [6:0]            daddr_out,
    input  logic                  drdy_in,
    input  logic [DRP_DATA_W-1:0] do_in,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [OUT_W-1:0]      m_data,
    output logic [CH_W-1:0]       m_ch,
    output logic                  overrun,
    output logic                  timeout_err,
    input  logic                  clr_flags
);

    localparam int TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC - 1);

    adc_state_e       state_q;
    logic             den_q;
    logic [6:0]       daddr_q;
    logic [4:0]       ch_q;
    logic [CH_W-1:0]  idx_q;
    logic [TMR_W-1:0] timer_q;
    logic [OUT_W-1:0] sample_q;
    logic             timeout_q;

    logic             m_valid_q;
    logic [OUT_W-1:0] m_data_q;
    logic [CH_W-1:0]  m_ch_q;
    logic             overrun_q;

    logic             ch_in_range_d;
    logic [CH_W-1:0]  idx_d;
    logic             acc_wr_d;
    logic             acc_done;
    logic [OUT_W-1:0] acc_avg;
    logic             new_res_d;

    // Bits of do_in below the MSB-justified result are not needed
    logic unused_do;
    assign unused_do = ^do_in;

    // Widened to 6 bits so CH_BASE+NUM_CH past 31 compares correctly
    assign ch_in_range_d = (6'(channel_in) >= 6'(CH_BASE)) &&
                           (6'(channel_in) <  6'(CH_BASE) + 6'(NUM_CH));
    assign idx_d         = CH_W'(channel_in - CH_BASE);

    // ------------------------------------------------------------------
    // Capture FSM: eoc -> DRP read -> accumulate
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            den_q     <= 1'b0;
            daddr_q   <= '0;
            ch_q      <= '0;
            idx_q     <= '0;
            timer_q   <= '0;
            sample_q  <= '0;
            timeout_q <= 1'b0;
        end else begin
            den_q <= 1'b0;
            if (clr_flags) begin
                timeout_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (eoc_in && enable && ch_in_range_d) begin
                        ch_q    <= channel_in;
                        idx_q   <= idx_d;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    den_q   <= 1'b1;
                    daddr_q <= {2'b00, ch_q};
                    timer_q <= '0;
                    state_q <= ST_WAIT_DRDY;
                end
                ST_WAIT_DRDY: begin
                    if (drdy_in) begin
                        sample_q <= do_in[DRP_DATA_W-1 -: OUT_W];
                        state_q  <= ST_ACCUM;
                    end else if (timer_q == TMR_LAST) begin
                        // Placed after the clear so a coincident clr_flags loses
                        timeout_q <= 1'b1;
                        state_q   <= ST_IDLE;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                ST_ACCUM: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign acc_wr_d = (state_q == ST_ACCUM);

    adc_ch_accum #(
        .NUM_CH   (NUM_CH),
        .OUT_W    (OUT_W),
        .AVG_LOG2 (AVG_LOG2),
        .IDX_W    (CH_W)
    ) u_accum (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (acc_wr_d),
        .idx_i    (idx_q),
        .sample_i (sample_q),
        .done_o   (acc_done),
        .avg_o    (acc_avg)
    );

    assign new_res_d = acc_wr_d && acc_done;

    // ------------------------------------------------------------------
    // Single-entry output slot and overrun flag
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
            m_data_q  <= '0;
            m_ch_q    <= '0;
            overrun_q <= 1'b0;
        end else begin
            if (clr_flags) begin
                overrun_q <= 1'b0;
            end
            if (new_res_d) begin
                // A slot draining this cycle can accept the new result
                if (!m_valid_q || m_ready) begin
                    m_valid_q <= 1'b1;
                    m_data_q  <= acc_avg;
                    m_ch_q    <= idx_q;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
        end
    end

    assign den_out     = den_q;
    assign daddr_out   = daddr_q;
    assign m_valid     = m_valid_q;
    assign m_data      = m_data_q;
    assign m_ch        = m_ch_q;
    assign overrun     = overrun_q;
    assign timeout_err = timeout_q;

endmodule : adc_multich_capture
`default_nettype wire
